// File: rtl/risc_pkg.sv
// Shared types and helpers for the RV32I data-memory path.
package risc_pkg;

  // Access width encoding from the core's mem_size field; 2'b10 never legal.
  typedef enum logic [1:0] {
    MEM_BYTE    = 2'b00,
    MEM_HALF    = 2'b01,
    MEM_ILLEGAL = 2'b10,
    MEM_WORD    = 2'b11
  } mem_size_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } mem_rsp_state_t;

  typedef logic [3:0] byte_en_t;

  // Request fields captured at accept time.
  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    mem_size_t   size;
    logic        zero_ext;
    logic [31:0] wdata;
  } mem_req_t;

  // Lanes touched by an access of the given size at the given word offset.
  function automatic byte_en_t mem_byte_en(mem_size_t size, logic [1:0] off);
    case (size)
      MEM_BYTE: return byte_en_t'(4'b0001 << off);
      MEM_HALF: return off[1] ? 4'b1100 : 4'b0011;
      MEM_WORD: return 4'b1111;
      default:  return 4'b0000;
    endcase
  endfunction

  // Right-aligned store data copied into every lane so byte enables pick it.
  function automatic logic [31:0] mem_store_replicate(logic [31:0] wdata, mem_size_t size);
    case (size)
      MEM_BYTE: return {4{wdata[7:0]}};
      MEM_HALF: return {2{wdata[15:0]}};
      default:  return wdata;
    endcase
  endfunction

  // Pick the addressed lane out of a RAM word and extend it to 32 bits.
  function automatic logic [31:0] mem_load_extend(logic [31:0] word, mem_size_t size,
                                                  logic [1:0] off, logic zero_ext);
    logic [31:0] lane;
    lane = word >> {off, 3'b000};
    case (size)
      MEM_BYTE: return zero_ext ? {24'h0, lane[7:0]} : {{24{lane[7]}}, lane[7:0]};
      MEM_HALF: return zero_ext ? {16'h0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
      MEM_WORD: return word;
      default:  return 32'h0;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_array.sv
// Word-organised RAM: byte-enable synchronous write, asynchronous read, no reset.
module data_mem_array #(
  parameter int DEPTH_WORDS = 1024,
  parameter int ADDR_W      = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [3:0]        be,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [31:0]       wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [31:0]       rdata
);

  logic [31:0] mem_q [DEPTH_WORDS];

  // Commit only the enabled byte lanes of the addressed word.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem_q[waddr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/data_mem_responder.sv
// Load/store target for the RV32I core with programmable wait states and fault checks.
module data_mem_responder
  import risc_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_zero_ext,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int ADDR_W = $clog2(DEPTH_WORDS);

  mem_rsp_state_t state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;
  mem_req_t       req_q, req_d;
  mem_req_t       in_req, cur_req;
  logic           accept;
  logic           cur_err;
  logic           ram_we;
  logic [31:0]    ram_rdata;

  assign accept = req_ready & req_valid;

  assign in_req = '{write:    req_write,
                    addr:     req_addr,
                    size:     mem_size_t'(req_size),
                    zero_ext: req_zero_ext,
                    wdata:    req_wdata};

  // Control state; aborting on reset leaves no pending response or write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Request capture is pure data and needs no reset.
  always_ff @(posedge clk) begin
    req_q <= req_d;
  end

  // Hold captured fields until the next accept.
  always_comb begin
    req_d = accept ? in_req : req_q;
  end

  // With zero wait states the write edge is the accept edge itself, so the
  // live request is used in IDLE and the captured copy everywhere else.
  always_comb begin
    cur_req = (state_q == IDLE) ? in_req : req_q;
    cur_err = (cur_req.size == MEM_ILLEGAL)
            | ((cur_req.size == MEM_HALF) & cur_req.addr[0])
            | ((cur_req.size == MEM_WORD) & (cur_req.addr[1:0] != 2'b00))
            | ({2'b00, cur_req.addr[31:2]} >= 32'(DEPTH_WORDS));
  end

  // Next-state and wait-state counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (WAIT_CYCLES > 0) begin
            state_d = WAIT;
            cnt_d   = 4'(WAIT_CYCLES - 1);
          end else begin
            state_d = RESP;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) state_d = RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Store commits on the edge that enters RESP, never for faulting accesses.
  always_comb begin
    ram_we = cur_req.write & ~cur_err & (state_d == RESP) & (state_q != RESP);
  end

  data_mem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .ADDR_W      (ADDR_W)
  ) u_array (
    .clk   (clk),
    .we    (ram_we),
    .be    (mem_byte_en(cur_req.size, cur_req.addr[1:0])),
    .waddr (cur_req.addr[ADDR_W+1:2]),
    .wdata (mem_store_replicate(cur_req.wdata, cur_req.size)),
    .raddr (req_q.addr[ADDR_W+1:2]),
    .rdata (ram_rdata)
  );

  // Handshake and response outputs; data is forced to zero outside RESP.
  always_comb begin
    req_ready = rst_n & (state_q == IDLE);
    rsp_valid = (state_q == RESP);
    rsp_err   = rsp_valid & cur_err;
    rsp_rdata = 32'h0;
    if (rsp_valid && !cur_err && !req_q.write) begin
      rsp_rdata = mem_load_extend(ram_rdata, req_q.size, req_q.addr[1:0], req_q.zero_ext);
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized self-checking bench for data_mem_responder against a byte-array model.
module tb_data_mem_responder;

  localparam int DEPTH = 1024;
  localparam int WAITC = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_write = 1'b0, req_zero_ext = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [1:0]  req_size = '0;
  logic        req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;

  logic        v0 = 1'b0, w0 = 1'b0, z0 = 1'b0;
  logic [31:0] a0 = '0, d0 = '0;
  logic [1:0]  s0 = '0;
  logic        r0, rv0, re0;
  logic [31:0] rd0;

  int n_chk = 0;
  int n_pass = 0;
  logic [7:0] mdl [0:255];

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAITC)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_size(req_size),
    .req_zero_ext(req_zero_ext), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err));

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .req_valid(v0), .req_ready(r0),
    .req_write(w0), .req_addr(a0), .req_size(s0),
    .req_zero_ext(z0), .req_wdata(d0), .rsp_valid(rv0),
    .rsp_rdata(rd0), .rsp_err(re0));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // One transaction on the main DUT, checked against the model.
  task automatic do_req(input logic w, input logic [31:0] a, input logic [1:0] sz,
                        input logic zx, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er);
    int n, ai, lat;
    logic e_err;
    logic [31:0] e_rd;
    logic [63:0] v;
    n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    e_err = (sz == 2'd2) || (sz == 2'd1 && a % 2 != 0) || (sz == 2'd3 && a % 4 != 0)
            || (a / 4 >= DEPTH);
    e_rd = 32'h0;
    ai = int'(a[7:0]);
    if (!e_err && !w) begin
      v = 64'h0;
      for (int i = 0; i < n; i++) v = v + (64'(mdl[ai+i]) << (8*i));
      if (!zx && n < 4 && v[8*n-1]) v = v - (64'd1 << (8*n));
      e_rd = v[31:0];
    end
    @(negedge clk);
    chk("ready_idle", {31'h0, req_ready}, 32'd1);
    req_valid = 1'b1; req_write = w; req_addr = a; req_size = sz;
    req_zero_ext = zx; req_wdata = wd;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_write = $urandom; req_addr = $urandom;
    req_size = 2'($urandom); req_zero_ext = $urandom; req_wdata = $urandom;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rsp_valid && lat < 20);
    chk("latency", 32'(lat), 32'(WAITC + 1));
    rd = rsp_rdata;
    er = rsp_err;
    chk("rsp_err", {31'h0, er}, {31'h0, e_err});
    chk("rsp_rdata", rd, e_rd);
    chk("ready_resp", {31'h0, req_ready}, 32'd0);
    if (w && !e_err)
      for (int i = 0; i < n; i++) mdl[ai+i] = 8'(wd >> (8*i));
    @(negedge clk);
    chk("rsp_pulse", {31'h0, rsp_valid}, 32'd0);
    chk("rdata_idle", rsp_rdata, 32'h0);
  endtask

  initial begin
    logic [31:0] rd;
    logic er, seen;
    logic [31:0] a;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'h0, req_ready}, 32'd0);
    chk("rst_valid", {31'h0, rsp_valid}, 32'd0);
    chk("rst_rdata", rsp_rdata, 32'h0);
    chk("rst_err", {31'h0, rsp_err}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", {31'h0, req_ready}, 32'd1);

    // Give every word in the test window known contents
    for (int i = 0; i < 64; i++) do_req(1'b1, 32'(i*4), 2'd3, 1'b0, $urandom, rd, er);

    // Directed load/store cases
    do_req(1'b1, 32'h10, 2'd3, 1'b0, 32'hDEADBEEF, rd, er);
    do_req(1'b0, 32'h10, 2'd3, 1'b0, 32'h0, rd, er);  chk("lw10", rd, 32'hDEADBEEF);
    do_req(1'b0, 32'h13, 2'd0, 1'b0, 32'h0, rd, er);  chk("lb13", rd, 32'hFFFFFFDE);
    do_req(1'b0, 32'h13, 2'd0, 1'b1, 32'h0, rd, er);  chk("lbu13", rd, 32'h000000DE);
    do_req(1'b0, 32'h10, 2'd1, 1'b0, 32'h0, rd, er);  chk("lh10", rd, 32'hFFFFBEEF);
    do_req(1'b0, 32'h12, 2'd1, 1'b1, 32'h0, rd, er);  chk("lhu12", rd, 32'h0000DEAD);
    do_req(1'b1, 32'h11, 2'd0, 1'b0, 32'h12345678, rd, er);
    do_req(1'b0, 32'h10, 2'd3, 1'b0, 32'h0, rd, er);  chk("lw_after_sb", rd, 32'hDEAD78EF);

    // Fault cases
    do_req(1'b0, 32'h11, 2'd1, 1'b0, 32'h0, rd, er);  chk("lh_mis_err", {31'h0, er}, 32'd1);
    do_req(1'b1, 32'h12, 2'd3, 1'b0, 32'h55555555, rd, er); chk("sw_mis_err", {31'h0, er}, 32'd1);
    do_req(1'b0, 32'h10, 2'd3, 1'b0, 32'h0, rd, er);  chk("lw_unchanged", rd, 32'hDEAD78EF);
    do_req(1'b0, 32'h10, 2'd2, 1'b0, 32'h0, rd, er);  chk("size10_err", {31'h0, er}, 32'd1);
    do_req(1'b0, 32'(DEPTH*4), 2'd3, 1'b0, 32'h0, rd, er); chk("oor_err", {31'h0, er}, 32'd1);

    // Reset during WAIT aborts a store
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20; req_size = 2'd3; req_wdata = 32'h0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("ready_in_rst", {31'h0, req_ready}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      seen = seen | rsp_valid;
    end
    chk("no_rsp_after_abort", {31'h0, seen}, 32'd0);
    do_req(1'b0, 32'h20, 2'd3, 1'b0, 32'h0, rd, er);

    // Random traffic
    for (int t = 0; t < 150; t++) begin
      if ($urandom_range(0, 15) == 0) a = 32'(DEPTH*4) + 32'($urandom_range(0, 4095));
      else a = 32'($urandom_range(0, 255));
      do_req($urandom, a, 2'($urandom), $urandom, $urandom, rd, er);
    end

    // Zero-wait build: back-to-back requests with valid held high
    @(negedge clk);
    chk("w0_ready", {31'h0, r0}, 32'd1);
    v0 = 1'b1; w0 = 1'b1; a0 = 32'h40; s0 = 2'd3; d0 = 32'hCAFEF00D;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("w0_rsp_valid", {31'h0, rv0}, {31'h0, k % 2 == 0});
      chk("w0_ready_alt", {31'h0, r0}, {31'h0, k % 2 == 1});
      if (k == 5) v0 = 1'b0;
    end
    @(negedge clk);
    v0 = 1'b1; w0 = 1'b0; a0 = 32'h40; s0 = 2'd3;
    @(negedge clk);
    v0 = 1'b0;
    chk("w0_lw_valid", {31'h0, rv0}, 32'd1);
    chk("w0_lw_data", rd0, 32'hCAFEF00D);
    chk("w0_lw_err", {31'h0, re0}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Data-memory responder for the RV32I core: it accepts load/store requests issued from the core's `mem_valid`/`mem_write`/`mem_size`/`load_zero_extend` control fields, performs byte/halfword/word access on an internal word-organised RAM, and returns sign- or zero-extended load data. It sits on the data side of the core as the target of every load and store. It applies a programmable wait-state latency and flags misaligned, out-of-range or malformed accesses.

## Interface
Parameters:
- `DEPTH_WORDS`, 1024 — RAM depth in 32-bit words; power of two.
- `WAIT_CYCLES`, 1 — extra latency cycles between accept and response; valid range 0–15.

Ports:
- `clk` in 1 — single clock, rising edge.
- `rst_n` in 1 — asynchronous, active-low reset.
- `req_valid` in 1 — request present (driven from `mem_valid`).
- `req_ready` out 1 — responder can accept a request.
- `req_write` in 1 — 1 = store, 0 = load.
- `req_addr` in 32 — byte address.
- `req_size` in 2 — `mem_size_t`: byte 00, halfword 01, word 11; 10 is illegal.
- `req_zero_ext` in 1 — loads only: 1 = zero-extend, 0 = sign-extend.
- `req_wdata` in 32 — store data, right-aligned (byte in [7:0], half in [15:0]).
- `rsp_valid` out 1 — one-cycle response pulse.
- `rsp_rdata` out 32 — extended load data; 0 for stores and errors.
- `rsp_err` out 1 — access faulted; qualified by `rsp_valid`.

## Operation
- FSM states: `IDLE`, `WAIT`, `RESP`.
- `IDLE`: `req_ready`=1. When `req_valid` is 1, the request is accepted and all `req_*` fields are latched. Next state is `WAIT` if WAIT_CYCLES>0, else `RESP`.
- `WAIT`: `req_ready`=0. A down-counter loaded with WAIT_CYCLES−1 decrements each cycle; at 0 the FSM goes to `RESP`.
- `RESP`: `rsp_valid`=1 for exactly one cycle, `req_ready`=0, then the FSM returns to `IDLE`.
- Error conditions, checked on latched fields:
  - size 10;
  - halfword with addr[0]=1;
  - word with addr[1:0]≠0;
  - addr[31:2] ≥ DEPTH_WORDS.
  - On error: `rsp_err`=1, `rsp_rdata`=0, and no RAM write.
- Stores:
  - byte enables come from size and addr[1:0];
  - `req_wdata` is replicated into the selected lanes;
  - the write commits on the clock edge that enters `RESP`.
- Loads:
  - the word is read combinationally in `RESP`;
  - the lane is selected by addr[1:0];
  - the result is sign- or zero-extended to 32 bits according to `req_zero_ext`.
  - `req_zero_ext` is ignored for word loads and for stores.
- Read-after-write: a load accepted after a store's `RESP` returns the stored data.

## Timing
- Reset values: `req_ready`=0 while `rst_n`=0 and 1 from the first cycle after release; `rsp_valid`=0; `rsp_rdata`=0; `rsp_err`=0; FSM in `IDLE`; counter 0.
- Reset does not clear the RAM array.
- Latency: for a request accepted at edge E, `rsp_valid` is high in the cycle after edge E+WAIT_CYCLES+1 − 1, i.e. WAIT_CYCLES+1 cycles after acceptance.
- Throughput: one request per WAIT_CYCLES+2 cycles.
- `req_*` may change freely after acceptance. `req_valid` asserted while `req_ready`=0 is ignored; there is no queuing.
- Reset mid-operation (in `WAIT` or `RESP`) aborts the access: no response is issued, and a store that has not yet reached `RESP` is never written.
- `rsp_rdata` and `rsp_err` are registered or held stable for the whole `rsp_valid` cycle, and are 0 otherwise.

## Structure
- Add to `risc_pkg`:
  - `mem_rsp_state_t` enum (`IDLE`, `WAIT`, `RESP`);
  - `byte_en_t` (logic [3:0]);
  - function `mem_byte_en(mem_size_t, logic [1:0])`;
  - function `mem_load_extend(logic [31:0], mem_size_t, logic [1:0], logic)`.
- Reuse `mem_size_t` from `risc_pkg`.
- Sub-module `data_mem_array`: DEPTH_WORDS×32 RAM with a 4-bit byte-enable write port and an asynchronous read port, no reset.

## Test plan
- Store word 0xDEADBEEF @0x10, then load word @0x10 → `rsp_rdata`=0xDEADBEEF, `rsp_err`=0; `rsp_valid` exactly WAIT_CYCLES+1 cycles after each accept.
- After the above: LB @0x13 → 0xFFFFFFDE; LBU @0x13 → 0x000000DE; LH @0x10 → 0xFFFFBEEF; LHU @0x12 → 0x0000DEAD.
- SB 0x12345678 @0x11, then LW @0x10 → 0xDEAD78EF (only lane 1 changed).
- Error cases:
  - LH @0x11 → `rsp_err`=1, `rsp_rdata`=0;
  - SW @0x12 → `rsp_err`=1, and a following LW @0x10 is unchanged;
  - size 10 → `rsp_err`=1;
  - addr = DEPTH_WORDS×4 → `rsp_err`=1.
- Pulse `rst_n` low during `WAIT` of SW 0x0 @0x20 → no `rsp_valid`; a following LW @0x20 returns the prior contents.
- WAIT_CYCLES=0 build: back-to-back `req_valid` held high → accepts every 2nd cycle, `rsp_valid` one cycle after each accept, `req_ready` low in `RESP`.
